// File: rtl/hazard_stall_unit.sv
// RAW/branch hazard stall unit with a shift-register scoreboard of in-flight destinations.
// Optional feature macro: HAZARD_FORWARD_EN (EX/MEM forwarding present, load-use stalls only).
module hazard_stall_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int WB_BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_en,
  input  logic                  id_usesRs,
  input  logic                  id_usesRt,
  input  logic [REG_ADDR_W-1:0] id_rsAddr,
  input  logic [REG_ADDR_W-1:0] id_rtAddr,
  input  logic                  id_ifWriteRegsFile,
  input  logic [REG_ADDR_W-1:0] id_registerWriteAddress,
  input  logic                  id_memOutOrAluOutWriteBackToRegFile,
  input  logic                  ex_shouldJumpOrBranch,
  output logic                  id_shouldStall,
  output logic                  pc_hold,
  output logic                  ifid_flush,
  output logic [15:0]           stall_cycles
);

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  // Only slots that can still cause a stall are tracked; later slots are covered by
  // forwarding or by the write-before-read register file.
  localparam int TRACK = FWD_EN ? 1 : (PIPE_DEPTH - WB_BYPASS);

  logic [TRACK-1:0]                 slotValid_r;
  logic [TRACK-1:0]                 slotLoad_r;
  logic [TRACK-1:0][REG_ADDR_W-1:0] slotAddr_r;
  logic [15:0]                      stallCnt_r;
  logic                             raw_s;
  logic                             branch_s;
  logic                             bubble_s;
  logic                             wrValid_s;

  function automatic logic regHit(
    input logic [REG_ADDR_W-1:0]            a,
    input logic [TRACK-1:0]                 v,
    input logic [TRACK-1:0]                 ld,
    input logic [TRACK-1:0][REG_ADDR_W-1:0] ad
  );
    logic h;
    h = 1'b0;
    for (int i = 0; i < TRACK; i++) begin
      if (v[i] && (ad[i] == a) && (ld[i] || !FWD_EN)) begin
        h = 1'b1;
      end else begin
        h = h;
      end
    end
    return h && (a != {REG_ADDR_W{1'b0}});
  endfunction

  // Hazard detection and pipeline control; branch wins over a simultaneous RAW.
  always_comb begin
    raw_s          = 1'b0;
    branch_s       = ex_shouldJumpOrBranch;
    bubble_s       = 1'b0;
    wrValid_s      = 1'b0;
    id_shouldStall = 1'b0;
    pc_hold        = 1'b0;
    ifid_flush     = 1'b0;
    raw_s = (id_usesRs && regHit(id_rsAddr, slotValid_r, slotLoad_r, slotAddr_r)) ||
            (id_usesRt && regHit(id_rtAddr, slotValid_r, slotLoad_r, slotAddr_r));
    bubble_s  = raw_s || branch_s;
    wrValid_s = id_ifWriteRegsFile && (id_registerWriteAddress != {REG_ADDR_W{1'b0}}) && !bubble_s;
    if (rst) begin
      id_shouldStall = 1'b0;
      pc_hold        = 1'b0;
      ifid_flush     = 1'b0;
    end else begin
      id_shouldStall = bubble_s;
      pc_hold        = raw_s && !branch_s;
      ifid_flush     = branch_s;
    end
  end

  // Scoreboard shift register, advancing with the pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slotValid_r <= {TRACK{1'b0}};
      slotLoad_r  <= {TRACK{1'b0}};
      slotAddr_r  <= {(TRACK*REG_ADDR_W){1'b0}};
    end else if (cpu_en) begin
      for (int i = 1; i < TRACK; i++) begin
        slotValid_r[i] <= slotValid_r[i-1];
        slotLoad_r[i]  <= slotLoad_r[i-1];
        slotAddr_r[i]  <= slotAddr_r[i-1];
      end
      slotValid_r[0] <= wrValid_s;
      slotLoad_r[0]  <= wrValid_s && id_memOutOrAluOutWriteBackToRegFile;
      slotAddr_r[0]  <= wrValid_s ? id_registerWriteAddress : {REG_ADDR_W{1'b0}};
    end else begin
      slotValid_r <= slotValid_r;
      slotLoad_r  <= slotLoad_r;
      slotAddr_r  <= slotAddr_r;
    end
  end

  // Saturating count of cycles lost to RAW stalls (branch flushes are not counted).
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_r <= 16'h0000;
    end else if (cpu_en && raw_s && !branch_s && (stallCnt_r != 16'hFFFF)) begin
      stallCnt_r <= stallCnt_r + 16'h0001;
    end else begin
      stallCnt_r <= stallCnt_r;
    end
  end

  assign stall_cycles = stallCnt_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Table-driven bench for hazard_stall_unit; expectations follow HAZARD_FORWARD_EN when defined.
module tb_hazard_stall_unit;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic        id_usesRs;
  logic        id_usesRt;
  logic [4:0]  id_rsAddr;
  logic [4:0]  id_rtAddr;
  logic        id_ifWriteRegsFile;
  logic [4:0]  id_registerWriteAddress;
  logic        id_memOutOrAluOutWriteBackToRegFile;
  logic        ex_shouldJumpOrBranch;
  logic        id_shouldStall;
  logic        pc_hold;
  logic        ifid_flush;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, en, uRs, uRt, wr, ld, br;
    logic [4:0]  rs, rt, wa;
    logic        eS, eH, eF, chk;
    logic [15:0] eCnt;
  } vec_t;

  vec_t vecs[$];

  hazard_stall_unit dut (
    .clk(clk),
    .rst(rst),
    .cpu_en(cpu_en),
    .id_usesRs(id_usesRs),
    .id_usesRt(id_usesRt),
    .id_rsAddr(id_rsAddr),
    .id_rtAddr(id_rtAddr),
    .id_ifWriteRegsFile(id_ifWriteRegsFile),
    .id_registerWriteAddress(id_registerWriteAddress),
    .id_memOutOrAluOutWriteBackToRegFile(id_memOutOrAluOutWriteBackToRegFile),
    .ex_shouldJumpOrBranch(ex_shouldJumpOrBranch),
    .id_shouldStall(id_shouldStall),
    .pc_hold(pc_hold),
    .ifid_flush(ifid_flush),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, en, uRs, rs, uRt, rt, wr, ld, wa, br,
                              input int eS, eH, eF, chk, eCnt);
    vec_t v;
    v.rst = r[0]; v.en = en[0]; v.uRs = uRs[0]; v.rs = rs[4:0];
    v.uRt = uRt[0]; v.rt = rt[4:0]; v.wr = wr[0]; v.ld = ld[0];
    v.wa = wa[4:0]; v.br = br[0]; v.eS = eS[0]; v.eH = eH[0]; v.eF = eF[0];
    v.chk = chk[0]; v.eCnt = eCnt[15:0];
    return v;
  endfunction

  // Expected counter value for the non-forwarding and forwarding builds.
  function automatic int c(input int d, input int f);
    return FWD ? f : d;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; cpu_en = v.en;
    id_usesRs = v.uRs; id_rsAddr = v.rs;
    id_usesRt = v.uRt; id_rtAddr = v.rt;
    id_ifWriteRegsFile = v.wr; id_memOutOrAluOutWriteBackToRegFile = v.ld;
    id_registerWriteAddress = v.wa; ex_shouldJumpOrBranch = v.br;
    #1;
    checks++;
    if ({id_shouldStall, pc_hold, ifid_flush} !== {v.eS, v.eH, v.eF}) begin
      errors++;
      $display("FAIL vec%0d stall/hold/flush got %b%b%b want %b%b%b", idx,
               id_shouldStall, pc_hold, ifid_flush, v.eS, v.eH, v.eF);
    end
    if (v.chk) begin
      checks++;
      if (stall_cycles !== v.eCnt) begin
        errors++;
        $display("FAIL vec%0d stall_cycles got %h want %h", idx, stall_cycles, v.eCnt);
      end
    end
  endtask

  initial begin
    int ns; int nf;
    ns = FWD ? 0 : 1;
    rst = 1'b1; cpu_en = 1'b1; id_usesRs = 1'b0; id_usesRt = 1'b0;
    id_rsAddr = 5'd0; id_rtAddr = 5'd0; id_ifWriteRegsFile = 1'b0;
    id_registerWriteAddress = 5'd0; id_memOutOrAluOutWriteBackToRegFile = 1'b0;
    ex_shouldJumpOrBranch = 1'b0;

    // rst   en uRs rs uRt rt wr ld wa br   S  H  F  chk cnt
    vecs.push_back(mk(1, 1, 1, 3, 0, 0, 1, 0, 3, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0));
    // back-to-back ALU dependency on $3
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 3, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0,  ns, ns, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0,  ns, ns, 0, 1, c(1, 0)));
    vecs.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, c(2, 0)));
    // load-use on rt $5
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 5, 0,  0, 0, 0, 1, c(2, 0)));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5, 0, 0, 0, 0,  1, 1, 0, 1, c(2, 0)));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5, 0, 0, 0, 0,  ns, ns, 0, 1, c(3, 1)));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5, 0, 0, 0, 0,  0, 0, 0, 1, c(4, 1)));
    // $0 is never a hazard
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 1, c(4, 1)));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, c(4, 1)));
    // matching address on an unused operand, then a MEM-slot hit
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 7, 0,  0, 0, 0, 1, c(4, 1)));
    vecs.push_back(mk(0, 1, 0, 7, 1, 8, 0, 0, 0, 0,  0, 0, 0, 1, c(4, 1)));
    vecs.push_back(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 0,  ns, ns, 0, 1, c(4, 1)));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, c(5, 1)));
    // branch together with raw, then branch alone
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 9, 0,  0, 0, 0, 1, c(5, 1)));
    vecs.push_back(mk(0, 1, 1, 9, 0, 0, 0, 0, 0, 1,  1, 0, 1, 1, c(5, 1)));
    vecs.push_back(mk(0, 1, 1, 9, 0, 0, 0, 0, 0, 0,  ns, ns, 0, 1, c(5, 1)));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 1, c(6, 1)));
    // cpu_en low for 5 cycles while stalled
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 10, 0, 0, 0, 0, 1, c(6, 1)));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, c(6, 1)));
    vecs.push_back(mk(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, c(6, 1)));
    vecs.push_back(mk(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, ns, ns, 0, 1, c(7, 2)));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, c(8, 2)));
    // a write presented while cpu_en is low never enters the scoreboard
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 11, 0, 0, 0, 0, 1, c(8, 2)));
    vecs.push_back(mk(0, 1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, c(8, 2)));
    // reset mid-stall with cpu_en low
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 12, 0, 0, 0, 0, 1, c(8, 2)));
    vecs.push_back(mk(0, 1, 1, 12, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, c(8, 2)));
    vecs.push_back(mk(1, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, c(9, 3)));
    vecs.push_back(mk(0, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Saturation: preload the counter just below the ceiling, then cause three stalls.
    @(negedge clk);
    force dut.stallCnt_r = 16'hFFFE;
    #1;
    release dut.stallCnt_r;
    nf = 100;
    apply(mk(0, 1, 0, 0, 0, 0, 1, 1, 13, 0, 0, 0, 0, 1, 16'hFFFE), nf++);
    apply(mk(0, 1, 1, 13, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 16'hFFFE), nf++);
    apply(mk(0, 1, 0, 0, 0, 0, 1, 1, 13, 0, 0, 0, 0, 1, 16'hFFFF), nf++);
    apply(mk(0, 1, 1, 13, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 16'hFFFF), nf++);
    apply(mk(0, 1, 0, 0, 0, 0, 1, 1, 13, 0, 0, 0, 0, 1, 16'hFFFF), nf++);
    apply(mk(0, 1, 1, 13, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 16'hFFFF), nf++);
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 16'hFFFF), nf++);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
